// File: rtl/fb_write_arbiter_pkg.sv
// Shared framebuffer types and constants for the write-port arbiter and its neighbours.
// The arbiter state enum is exported here so debug LEDs can decode it.
package fb_write_arbiter_pkg;

    localparam int ADDR_BITS    = 18;
    localparam int COLOR_BITS   = 16;
    localparam int FRAME_PIXELS = 196608;
    localparam logic [COLOR_BITS-1:0] CLEAR_COLOR = 16'h0000;

    typedef logic [ADDR_BITS-1:0]  fb_addr_t;
    typedef logic [COLOR_BITS-1:0] fb_color_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_CLEAR = 2'd2
    } arb_state_t;

endpackage

// File: rtl/fb_clear_counter.sv
// Loadable up-counter that walks the clear engine across the frame.
// tc flags the terminal address so the engine can stop on the final write.
module fb_clear_counter
    import fb_write_arbiter_pkg::*;
#(
    parameter int WIDTH = ADDR_BITS,
    parameter logic [WIDTH-1:0] TERMINAL = WIDTH'(FRAME_PIXELS - 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

    assign tc = (count == TERMINAL);

endmodule

// File: rtl/fb_write_arbiter.sv
// Owns framebuffer BRAM port A and shares it between the triangle fill stream
// and the frame-clear engine; a clear never splits a triangle and vice versa.
module fb_write_arbiter #(
    parameter int ADDR_BITS    = fb_write_arbiter_pkg::ADDR_BITS,
    parameter int COLOR_BITS   = fb_write_arbiter_pkg::COLOR_BITS,
    parameter int FRAME_PIXELS = fb_write_arbiter_pkg::FRAME_PIXELS,
    parameter logic [COLOR_BITS-1:0] CLEAR_COLOR = fb_write_arbiter_pkg::CLEAR_COLOR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic                  clear_done,
    input  logic                  fill_valid,
    output logic                  fill_ready,
    input  logic [ADDR_BITS-1:0]  fill_addr,
    input  logic [COLOR_BITS-1:0] fill_color,
    input  logic                  fill_last,
    output logic                  tri_done,
    output logic                  oob_err,
    output logic                  wea,
    output logic [ADDR_BITS-1:0]  addra,
    output logic [COLOR_BITS-1:0] dina
);

    import fb_write_arbiter_pkg::*;

    localparam logic [ADDR_BITS:0]   FRAME_LIMIT = (ADDR_BITS + 1)'(FRAME_PIXELS);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR   = ADDR_BITS'(FRAME_PIXELS - 1);

    arb_state_t           state;
    logic                 pending;
    logic                 clr_last_q;
    logic [ADDR_BITS-1:0] clr_cnt;
    logic                 clr_tc;
    logic                 accept;
    logic                 in_frame;

    // A clear request seen in IDLE wins the port over a simultaneous fill beat.
    assign fill_ready = rst_n && (state != ST_CLEAR)
                        && !((state == ST_IDLE) && (clear_req || pending));
    assign accept     = fill_valid && fill_ready;
    assign in_frame   = ({1'b0, fill_addr} < FRAME_LIMIT);
    assign clear_busy = rst_n && (pending || (state == ST_CLEAR)
                        || ((state == ST_IDLE) && clear_req));

    fb_clear_counter #(
        .WIDTH    (ADDR_BITS),
        .TERMINAL (LAST_ADDR)
    ) u_clear_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       ((state != ST_CLEAR) || clr_tc),
        .load_value ('0),
        .en         (state == ST_CLEAR),
        .count      (clr_cnt),
        .tc         (clr_tc)
    );

    // clear_done trails the final clear write by one cycle via clr_last_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pending    <= 1'b0;
            clr_last_q <= 1'b0;
            wea        <= 1'b0;
            addra      <= '0;
            dina       <= '0;
            tri_done   <= 1'b0;
            clear_done <= 1'b0;
            oob_err    <= 1'b0;
        end else begin
            wea        <= 1'b0;
            tri_done   <= 1'b0;
            clr_last_q <= 1'b0;
            clear_done <= clr_last_q;

            if (accept) begin
                wea      <= in_frame;
                addra    <= fill_addr;
                dina     <= fill_color;
                tri_done <= fill_last;
                if (!in_frame) begin
                    oob_err <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (clear_req || pending) begin
                        state <= ST_CLEAR;
                    end else if (accept && !fill_last) begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (clear_req) begin
                        pending <= 1'b1;
                    end
                    if (accept && fill_last) begin
                        state <= (pending || clear_req) ? ST_CLEAR : ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    wea   <= 1'b1;
                    addra <= clr_cnt;
                    dina  <= CLEAR_COLOR;
                    if (clr_tc) begin
                        state      <= ST_IDLE;
                        pending    <= 1'b0;
                        clr_last_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a write scoreboard; uses a small
// frame so every clear completes quickly.
module tb_fb_write_arbiter;

    localparam int AW = 18;
    localparam int CW = 16;
    localparam int FP = 64;

    logic          clk;
    logic          rst_n;
    logic          clear_req;
    logic          clear_busy;
    logic          clear_done;
    logic          fill_valid;
    logic          fill_ready;
    logic [AW-1:0] fill_addr;
    logic [CW-1:0] fill_color;
    logic          fill_last;
    logic          tri_done;
    logic          oob_err;
    logic          wea;
    logic [AW-1:0] addra;
    logic [CW-1:0] dina;

    typedef struct {
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
        logic          last;
        logic          is_clear;
    } wr_t;

    wr_t  sb[$];
    wr_t  mon_e;
    logic exp_cd;
    int   total;
    int   bad;

    fb_write_arbiter #(
        .FRAME_PIXELS (FP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .fill_addr  (fill_addr),
        .fill_color (fill_color),
        .fill_last  (fill_last),
        .tri_done   (tri_done),
        .oob_err    (oob_err),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [AW-1:0] a, input logic [CW-1:0] c,
                                 input logic l, input logic cr);
        fill_valid = v;
        fill_addr  = a;
        fill_color = c;
        fill_last  = l;
        clear_req  = cr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushFill(input logic [AW-1:0] a, input logic [CW-1:0] c, input logic l);
        wr_t e;
        e.addr     = a;
        e.data     = c;
        e.last     = l;
        e.is_clear = 1'b0;
        sb.push_back(e);
    endtask

    task automatic pushClear();
        wr_t e;
        for (int k = 0; k < FP; k++) begin
            e.addr     = AW'(k);
            e.data     = '0;
            e.last     = 1'b0;
            e.is_clear = 1'b1;
            sb.push_back(e);
        end
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        checkOutput(tag, 32'(sb.size()), 32'd0);
        step();
        step();
    endtask

    // Scoreboard: every write on the port must match the next expected entry.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_cd = 1'b0;
        end else begin
            checkOutput("clear_done", 32'(clear_done), 32'(exp_cd));
            exp_cd = 1'b0;
            if (wea) begin
                checkOutput("write_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    checkOutput("wr_addr", 32'(addra), 32'(mon_e.addr));
                    checkOutput("wr_data", 32'(dina), 32'(mon_e.data));
                    checkOutput("wr_tri_done", 32'(tri_done), 32'(mon_e.last));
                    if (mon_e.is_clear) begin
                        if (mon_e.addr == AW'(FP - 1)) begin
                            exp_cd = 1'b1;
                        end else begin
                            checkOutput("clr_fill_ready", 32'(fill_ready), 32'd0);
                            checkOutput("clr_busy", 32'(clear_busy), 32'd1);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        total  = 0;
        bad    = 0;
        exp_cd = 1'b0;
        rst_n  = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        #12;
        checkOutput("rst_wea", 32'(wea), 32'd0);
        checkOutput("rst_addra", 32'(addra), 32'd0);
        checkOutput("rst_dina", 32'(dina), 32'd0);
        checkOutput("rst_tri_done", 32'(tri_done), 32'd0);
        checkOutput("rst_clear_done", 32'(clear_done), 32'd0);
        checkOutput("rst_clear_busy", 32'(clear_busy), 32'd0);
        checkOutput("rst_oob", 32'(oob_err), 32'd0);
        checkOutput("rst_fill_ready", 32'(fill_ready), 32'd0);
        clear_req = 1'b0;
        #10 rst_n = 1'b1;
        step();

        $display("[TB] full-frame clear");
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        pushClear();
        #1;
        checkOutput("t1_busy_on_req", 32'(clear_busy), 32'd1);
        checkOutput("t1_ready_on_req", 32'(fill_ready), 32'd0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t1_busy", 32'(clear_busy), 32'd1);
        waitDrain("t1_drain", 4 * FP);
        checkOutput("t1_busy_after", 32'(clear_busy), 32'd0);

        $display("[TB] three-beat triangle");
        applyStimulus(1'b1, 18'd10, 16'h0F00, 1'b0, 1'b0);
        pushFill(18'd10, 16'h0F00, 1'b0);
        #1;
        checkOutput("t2_ready", 32'(fill_ready), 32'd1);
        step();
        checkOutput("t2_wea_b1", 32'(wea), 32'd1);
        checkOutput("t2_addr_b1", 32'(addra), 32'd10);
        applyStimulus(1'b1, 18'd11, 16'h0F00, 1'b0, 1'b0);
        pushFill(18'd11, 16'h0F00, 1'b0);
        step();
        checkOutput("t2_addr_b2", 32'(addra), 32'd11);
        checkOutput("t2_tri_b2", 32'(tri_done), 32'd0);
        applyStimulus(1'b1, 18'd12, 16'h0F00, 1'b1, 1'b0);
        pushFill(18'd12, 16'h0F00, 1'b1);
        step();
        checkOutput("t2_addr_b3", 32'(addra), 32'd12);
        checkOutput("t2_tri_b3", 32'(tri_done), 32'd1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        checkOutput("t2_wea_idle", 32'(wea), 32'd0);
        checkOutput("t2_tri_idle", 32'(tri_done), 32'd0);

        $display("[TB] clear requested mid-triangle");
        applyStimulus(1'b1, 18'd20, 16'h0AAA, 1'b0, 1'b0);
        pushFill(18'd20, 16'h0AAA, 1'b0);
        step();
        applyStimulus(1'b1, 18'd21, 16'h0AAA, 1'b0, 1'b1);
        pushFill(18'd21, 16'h0AAA, 1'b0);
        #1;
        checkOutput("t3_ready_fill_req", 32'(fill_ready), 32'd1);
        step();
        checkOutput("t3_busy_pending", 32'(clear_busy), 32'd1);
        applyStimulus(1'b1, 18'd22, 16'h0AAA, 1'b1, 1'b0);
        pushFill(18'd22, 16'h0AAA, 1'b1);
        pushClear();
        #1;
        checkOutput("t3_ready_last", 32'(fill_ready), 32'd1);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t3_tri_done", 32'(tri_done), 32'd1);
        checkOutput("t3_addr_last", 32'(addra), 32'd22);
        checkOutput("t3_ready_clear", 32'(fill_ready), 32'd0);
        step();
        checkOutput("t3_first_clr_wea", 32'(wea), 32'd1);
        checkOutput("t3_first_clr_addr", 32'(addra), 32'd0);
        waitDrain("t3_drain", 4 * FP);

        $display("[TB] clear and fill in the same idle cycle");
        applyStimulus(1'b1, 18'd30, 16'h0333, 1'b1, 1'b1);
        pushClear();
        pushFill(18'd30, 16'h0333, 1'b1);
        #1;
        checkOutput("t4_ready_tie", 32'(fill_ready), 32'd0);
        checkOutput("t4_busy_tie", 32'(clear_busy), 32'd1);
        step();
        clear_req = 1'b0;
        checkOutput("t4_ready_clear", 32'(fill_ready), 32'd0);
        repeat (FP) step();
        checkOutput("t4_last_clr_addr", 32'(addra), 32'(FP - 1));
        checkOutput("t4_ready_after", 32'(fill_ready), 32'd1);
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        checkOutput("t4_beat_wea", 32'(wea), 32'd1);
        checkOutput("t4_beat_addr", 32'(addra), 32'd30);
        checkOutput("t4_beat_done", 32'(clear_done), 32'd1);
        step();

        $display("[TB] out-of-frame beat");
        applyStimulus(1'b1, AW'(FP), 16'h1234, 1'b1, 1'b0);
        step();
        checkOutput("t5_wea_oob", 32'(wea), 32'd0);
        checkOutput("t5_oob_set", 32'(oob_err), 32'd1);
        checkOutput("t5_tri_oob", 32'(tri_done), 32'd1);
        applyStimulus(1'b1, 18'd40, 16'h5555, 1'b1, 1'b0);
        pushFill(18'd40, 16'h5555, 1'b1);
        step();
        checkOutput("t5_wea_ok", 32'(wea), 32'd1);
        checkOutput("t5_oob_sticky", 32'(oob_err), 32'd1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        step();
        step();
        checkOutput("t5_oob_held", 32'(oob_err), 32'd1);

        $display("[TB] reset during clear");
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        pushClear();
        step();
        clear_req = 1'b0;
        repeat (20) step();
        checkOutput("t6_pre_addr", 32'(addra), 32'd19);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_wea", 32'(wea), 32'd0);
        checkOutput("t6_addra", 32'(addra), 32'd0);
        checkOutput("t6_dina", 32'(dina), 32'd0);
        checkOutput("t6_tri_done", 32'(tri_done), 32'd0);
        checkOutput("t6_clear_done", 32'(clear_done), 32'd0);
        checkOutput("t6_clear_busy", 32'(clear_busy), 32'd0);
        checkOutput("t6_oob", 32'(oob_err), 32'd0);
        checkOutput("t6_fill_ready", 32'(fill_ready), 32'd0);
        sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        pushClear();
        step();
        clear_req = 1'b0;
        step();
        checkOutput("t6_restart_wea", 32'(wea), 32'd1);
        checkOutput("t6_restart_addr", 32'(addra), 32'd0);
        waitDrain("t6_drain", 4 * FP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
